dsp_mac_pipe: RTL and testbench

//  Parametrised, signed successor of the DSP48A1 slice: pre-adder, multiplier and post-adder/accumulator.

---
 rtl/dsp_pkg.sv | 15 +
 rtl/dsp_pipe_stage.sv | 21 ++
 rtl/dsp_mac_pipe.sv | 172 +++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared constants for the MAC slice: opmode bit positions and width.
package dsp_pkg;

    localparam int unsigned OPMODE_W = 5;

    // Bit positions inside the per-beat opmode word
    localparam int unsigned OPM_PRE_EN   = 0;
    localparam int unsigned OPM_PRE_SUB  = 1;
    localparam int unsigned OPM_ACC      = 2;
    localparam int unsigned OPM_POST_SUB = 3;
    localparam int unsigned OPM_CLR      = 4;

    typedef logic [OPMODE_W-1:0] opmode_t;

endpackage

// File: rtl/dsp_pipe_stage.sv
// Generic pipeline register: loads on enable, clears on asynchronous reset.
module dsp_pipe_stage #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Stage register; holds its value while the pipeline is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Signed pre-add / multiply / post-add-accumulate slice with valid/ready flow control,
// optional multiplier register and saturating or wrapping post-adder.
module dsp_mac_pipe
    import dsp_pkg::*;
#(
    parameter int unsigned A_W  = 18,
    parameter int unsigned B_W  = 18,
    parameter int unsigned C_W  = 48,
    parameter int unsigned P_W  = 48,
    parameter int unsigned MREG = 1,
    parameter int unsigned SAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [A_W-1:0]      a_in,
    input  logic [B_W-1:0]      b_in,
    input  logic [B_W-1:0]      d_in,
    input  logic [C_W-1:0]      c_in,
    input  logic [OPMODE_W-1:0] opmode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [P_W-1:0]      p_out,
    output logic                ovf
);

    localparam int unsigned M_W  = A_W + B_W + 1;
    localparam int unsigned S1_W = A_W + 2 * B_W + C_W + OPMODE_W;
    localparam int unsigned S2_W = P_W + C_W + 3;

    localparam logic [P_W-1:0] SAT_MAX = {1'b0, {(P_W - 1){1'b1}}};
    localparam logic [P_W-1:0] SAT_MIN = {1'b1, {(P_W - 1){1'b0}}};

    // A stalled, full output freezes every stage at once
    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // ---------------- S1: operand capture ----------------
    logic [S1_W-1:0]        s1_q;
    logic                   v1_q;
    logic signed [A_W-1:0]  a1;
    logic signed [B_W-1:0]  b1;
    logic signed [B_W-1:0]  d1;
    logic signed [C_W-1:0]  c1;
    logic [OPMODE_W-1:0]    opm1;

    dsp_pipe_stage #(.W(S1_W)) u_s1 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   ({a_in, b_in, d_in, c_in, opmode}),
        .q   (s1_q)
    );

    dsp_pipe_stage #(.W(1)) u_v1 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (in_valid),
        .q   (v1_q)
    );

    assign {a1, b1, d1, c1, opm1} = s1_q;

    // ---------------- Pre-adder and multiplier ----------------
    logic signed [B_W:0]   pre_sum;
    logic signed [B_W:0]   mult_b;
    logic signed [M_W-1:0] prod;
    logic signed [P_W-1:0] m1;

    // Pre-adder is one bit wider than its operands so it can never overflow
    always_comb begin
        pre_sum = (B_W + 1)'(d1) + (B_W + 1)'(b1);
        if (opm1[OPM_PRE_SUB]) begin
            pre_sum = (B_W + 1)'(d1) - (B_W + 1)'(b1);
        end
        mult_b = opm1[OPM_PRE_EN] ? pre_sum : (B_W + 1)'(b1);
        prod   = M_W'(a1) * M_W'(mult_b);
        m1     = P_W'(prod);
    end

    // ---------------- S2: optional multiplier register ----------------
    // C and the post-add opmode bits travel alongside M so they stay with their beat
    logic [S2_W-1:0]       s2_d;
    logic [S2_W-1:0]       s2_q;
    logic                  v2;
    logic signed [P_W-1:0] m2;
    logic signed [C_W-1:0] c2;
    logic                  clr2;
    logic                  sub2;
    logic                  acc2;

    assign s2_d = {m1, c1, opm1[OPM_CLR], opm1[OPM_POST_SUB], opm1[OPM_ACC]};

    if (MREG != 0) begin : g_mreg
        dsp_pipe_stage #(.W(S2_W)) u_s2 (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (s2_d),
            .q   (s2_q)
        );

        dsp_pipe_stage #(.W(1)) u_v2 (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (v1_q),
            .q   (v2)
        );
    end else begin : g_no_mreg
        assign s2_q = s2_d;
        assign v2   = v1_q;
    end

    assign {m2, c2, clr2, sub2, acc2} = s2_q;

    // ---------------- Z mux, post-adder, saturation ----------------
    logic [P_W-1:0]        p_q;
    logic                  ovf_q;
    logic signed [P_W-1:0] z;
    logic signed [P_W:0]   post_sum;
    logic [P_W-1:0]        res;
    logic                  ovf_d;

    // Post-add one bit wider than P; disagreeing top bits mean the result does not fit
    always_comb begin
        z = P_W'(c2);
        if (acc2) begin
            z = p_q;
        end
        if (clr2) begin
            z = '0;
        end
        post_sum = (P_W + 1)'(z) + (P_W + 1)'(m2);
        if (sub2) begin
            post_sum = (P_W + 1)'(z) - (P_W + 1)'(m2);
        end
        ovf_d = post_sum[P_W] ^ post_sum[P_W-1];
        res   = post_sum[P_W-1:0];
        if (ovf_d && (SAT != 0)) begin
            res = post_sum[P_W] ? SAT_MIN : SAT_MAX;
        end
    end

    // ---------------- S3: P register and output valid ----------------
    logic [P_W:0] p_stage_q;

    // P only moves on a real beat, so bubbles never disturb the accumulator
    dsp_pipe_stage #(.W(P_W + 1)) u_p (
        .clk (clk),
        .rst (rst),
        .en  (en && v2),
        .d   ({res, ovf_d}),
        .q   (p_stage_q)
    );

    dsp_pipe_stage #(.W(1)) u_vout (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (v2),
        .q   (out_valid)
    );

    assign {p_q, ovf_q} = p_stage_q;
    assign p_out        = p_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Scoreboard bench: a saturating and a wrapping slice share one stimulus stream; expected
// results are queued at acceptance and popped by an output monitor.
module tb_dsp_mac_pipe;

    localparam int A_W = 18;
    localparam int B_W = 18;
    localparam int C_W = 48;
    localparam int P_W = 48;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [A_W-1:0] a_in;
    logic [B_W-1:0] b_in;
    logic [B_W-1:0] d_in;
    logic [C_W-1:0] c_in;
    logic [4:0]     opmode;
    logic           out_ready;

    logic           in_ready_s, in_ready_w;
    logic           out_valid_s, out_valid_w;
    logic [P_W-1:0] p_out_s, p_out_w;
    logic           ovf_s, ovf_w;

    always #5 clk = ~clk;

    dsp_mac_pipe #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .P_W(P_W), .MREG(1), .SAT(1)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .a_in      (a_in),
        .b_in      (b_in),
        .d_in      (d_in),
        .c_in      (c_in),
        .opmode    (opmode),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .p_out     (p_out_s),
        .ovf       (ovf_s)
    );

    dsp_mac_pipe #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .P_W(P_W), .MREG(1), .SAT(0)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w),
        .a_in      (a_in),
        .b_in      (b_in),
        .d_in      (d_in),
        .c_in      (c_in),
        .opmode    (opmode),
        .out_valid (out_valid_w),
        .out_ready (out_ready),
        .p_out     (p_out_w),
        .ovf       (ovf_w)
    );

    typedef struct packed {
        logic [P_W-1:0] p;
        logic           ovf;
    } exp_t;

    exp_t           q_s[$];
    exp_t           q_w[$];
    longint         mp_s = 0;
    longint         mp_w = 0;
    int             checks = 0;
    int             failures = 0;
    int             ready_mode = 0;
    logic [P_W-1:0] last_s = '0;
    logic [P_W-1:0] last_w = '0;
    logic           last_ovf_s = 1'b0;
    logic           last_ovf_w = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic on the opmode rules, then range clamp or wrap
    function automatic void model(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                  input logic [B_W-1:0] d, input logic [C_W-1:0] c,
                                  input logic [4:0] op, input bit sat, input longint p_prev,
                                  output longint p_next, output logic ov);
        longint av, bv, dv, cv, pre, mb, m, z, t, lim;
        av  = longint'($signed(a));
        bv  = longint'($signed(b));
        dv  = longint'($signed(d));
        cv  = longint'($signed(c));
        pre = op[1] ? (dv - bv) : (dv + bv);
        mb  = op[0] ? pre : bv;
        m   = av * mb;
        z   = op[4] ? 64'sd0 : (op[2] ? p_prev : cv);
        t   = op[3] ? (z - m) : (z + m);
        lim = 64'sd1 <<< (P_W - 1);
        ov  = 1'b0;
        p_next = t;
        if (t > lim - 1) begin
            ov = 1'b1;
            p_next = sat ? (lim - 1) : (t - 2 * lim);
        end else if (t < -lim) begin
            ov = 1'b1;
            p_next = sat ? -lim : (t + 2 * lim);
        end
    endfunction

    // Output ready pattern, updated just after each rising edge
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: a transfer seen here completes on the next rising edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_ready) begin
            if (out_valid_s) begin
                if (q_s.size() == 0) begin
                    check("sat_unexpected_result", 64'(p_out_s), 64'hDEAD);
                end else begin
                    e = q_s.pop_front();
                    check("sat_p_out", 64'(p_out_s), 64'(e.p));
                    check("sat_ovf", 64'(ovf_s), 64'(e.ovf));
                    last_s = p_out_s;
                    last_ovf_s = ovf_s;
                end
            end
            if (out_valid_w) begin
                if (q_w.size() == 0) begin
                    check("wrap_unexpected_result", 64'(p_out_w), 64'hDEAD);
                end else begin
                    e = q_w.pop_front();
                    check("wrap_p_out", 64'(p_out_w), 64'(e.p));
                    check("wrap_ovf", 64'(ovf_w), 64'(e.ovf));
                    last_w = p_out_w;
                    last_ovf_w = ovf_w;
                end
            end
        end
    end

    // Offer one beat; called just after a rising edge, returns just after the accepting edge
    task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic [B_W-1:0] d, input logic [C_W-1:0] c, input logic [4:0] op);
        bit     ok;
        longint pn;
        logic   ov;
        exp_t   e;
        ok = 1'b0;
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        d_in = d;
        c_in = c;
        opmode = op;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (in_ready_s && in_ready_w && !rst) begin
                model(a, b, d, c, op, 1'b1, mp_s, pn, ov);
                mp_s = pn;
                e.p = pn[P_W-1:0];
                e.ovf = ov;
                q_s.push_back(e);
                model(a, b, d, c, op, 1'b0, mp_w, pn, ov);
                mp_w = pn;
                e.p = pn[P_W-1:0];
                e.ovf = ov;
                q_w.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && (q_s.size() != 0 || q_w.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_pending", 64'(q_s.size() + q_w.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_p_out"}, 64'(p_out_s), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid_s), 64'd0);
        check({tag, "_ovf"}, 64'(ovf_s), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready_s), 64'd1);
        check({tag, "_wrap_p_out"}, 64'(p_out_w), 64'd0);
    endtask

    initial begin
        int             lat;
        logic [P_W-1:0] hold;
        logic [63:0]    r64;

        rst = 1'b1;
        in_valid = 1'b0;
        a_in = '0;
        b_in = '0;
        d_in = '0;
        c_in = '0;
        opmode = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic MAC and its latency
        send(18'd3, 18'd5, 18'd0, 48'd7, 5'b00000);
        lat = 0;
        for (int i = 0; i < 20 && !out_valid_s; i++) begin
            @(negedge clk);
            lat++;
        end
        check("latency_cycles", 64'(lat), 64'd3);
        drain();
        check("basic_mac", 64'(last_s), 64'd22);
        check("basic_mac_ovf", 64'(last_ovf_s), 64'd0);

        // Pre-subtract: (10 - 4) * -2
        send(-18'sd2, 18'd4, 18'd10, 48'd0, 5'b00011);
        drain();
        check("pre_sub", 64'(last_s), 64'(48'hFFFF_FFFF_FFF4));

        // Clear then back-to-back accumulation
        send(18'd1, 18'd1, 18'd0, 48'd0, 5'b10000);
        repeat (4) send(18'd2, 18'd3, 18'd0, 48'd0, 5'b00100);
        drain();
        check("accumulate", 64'(last_s), 64'd25);

        // Load P with +max through C, then accumulate one more
        send(18'd0, 18'd0, 18'd0, 48'h7FFF_FFFF_FFFF, 5'b00000);
        send(18'd1, 18'd1, 18'd0, 48'd0, 5'b00100);
        drain();
        check("sat_pos", 64'(last_s), 64'(48'h7FFF_FFFF_FFFF));
        check("sat_pos_ovf", 64'(last_ovf_s), 64'd1);
        check("wrap_pos", 64'(last_w), 64'(48'h8000_0000_0000));
        check("wrap_pos_ovf", 64'(last_ovf_w), 64'd1);

        // Backpressure: output held for several cycles while the source keeps offering
        ready_mode = 2;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(18'($urandom), 18'($urandom), 18'($urandom), 48'($urandom),
                         5'b00100);
                end
            end
            begin
                repeat (8) @(negedge clk);
                hold = p_out_s;
                check("bp_out_valid", 64'(out_valid_s), 64'd1);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(in_ready_s), 64'd0);
                    check("bp_p_stable", 64'(p_out_s), 64'(hold));
                end
                @(posedge clk);
                #1;
                ready_mode = 0;
            end
        join
        drain();

        // Randomised stream with random backpressure
        ready_mode = 1;
        for (int i = 0; i < 200; i++) begin
            r64 = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) == 0) r64 = 64'($urandom_range(0, 1000));
            send(18'($urandom), 18'($urandom), 18'($urandom), r64[C_W-1:0],
                 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        ready_mode = 0;
        drain();

        // Reset with three beats stuck in the pipe
        ready_mode = 2;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(18'd5, 18'd7, 18'd0, 48'd9, 5'b00100);
        rst = 1'b1;
        q_s.delete();
        q_w.delete();
        mp_s = 0;
        mp_w = 0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;
        @(posedge clk);
        #1;
        send(18'd2, 18'd2, 18'd0, 48'd0, 5'b00100);
        drain();
        check("acc_after_reset", 64'(last_s), 64'd4);
        check("acc_after_reset_ovf", 64'(last_ovf_s), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
